// File: rtl/fll_pkg.sv
// Shared types and defaults for the I2S FLL word-rate comparator.
package fll_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ALIGN    = 3'd1,
        TRACK    = 3'd2,
        SPEEDUP  = 3'd3,
        SLOWDOWN = 3'd4
    } fll_state_e;

    localparam int BITS_PER_WORD_DEF  = 32;
    localparam int DIFF_W_DEF         = 8;
    localparam int THRESH_DEF         = 2;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    // One step up or down, clamped symmetrically to +/-lim.
    function automatic int sat_step(input int val, input logic up, input int lim);
        if (up) begin
            return (val >= lim) ? lim : val + 1;
        end
        return (val <= -lim) ? -lim : val - 1;
    endfunction

endpackage

// File: rtl/fll_tgl_sync.sv
// Brings a per-word toggle into the local clock domain and turns each edge
// of it into a single-cycle pulse.
module fll_tgl_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tgl_i,
    output logic pulse_o
);

    // [0],[1] form the synchroniser; [2] remembers the previous settled level.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], tgl_i};
        end
    end

    assign pulse_o = sync_q[2] ^ sync_q[1];

endmodule

// File: rtl/fll_wordcnt_compare.sv
// Master-vs-local word-rate comparator with hysteretic speedup/slowdown
// interrupts. Define FLL_TIMEOUT_EN to add the master-loss watchdog.
module fll_wordcnt_compare
    import fll_pkg::*;
#(
    parameter int BITS_PER_WORD  = BITS_PER_WORD_DEF,
    parameter int DIFF_W         = DIFF_W_DEF,
    parameter int THRESH         = THRESH_DEF
`ifdef FLL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic              CLK_IP_i,
    input  logic              RST_IP_i,
    input  logic              enable_i,
    input  logic              master_word_tgl_i,
    output logic              Interrupt_speedup,
    output logic              Interrupt_slowdown,
    output logic              master_wordcnt_is_ahead_o,
    output logic              local_wordcnt_is_ahead_o,
    output logic [DIFF_W-1:0] word_diff_o,
    output logic              locked_o,
    output logic              master_lost_o,
    output fll_state_e        state_o
);

    localparam int CNT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PER_WORD - 1);
    localparam int DMAX = (1 << (DIFF_W - 1)) - 1;
    localparam logic signed [DIFF_W-1:0] THR_P  = DIFF_W'(THRESH);
    localparam logic signed [DIFF_W-1:0] THR_N  = -THR_P;
    localparam logic signed [DIFF_W-1:0] ZERO_D = '0;

    fll_state_e               state_q, state_d;
    logic signed [DIFF_W-1:0] diff_q, diff_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     spd_q, slw_q, mah_q, lah_q;
    logic                     m_evt, l_evt, locked, locked_nxt;

    fll_tgl_sync u_sync (
        .clk_i   (CLK_IP_i),
        .rst_ni  (RST_IP_i),
        .tgl_i   (master_word_tgl_i),
        .pulse_o (m_evt)
    );

    assign locked = (state_q == TRACK) || (state_q == SPEEDUP) || (state_q == SLOWDOWN);
    assign l_evt  = locked && (cnt_q == CNT_LAST);

`ifdef FLL_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            lost_q, timeout;

    // Any master word restarts the watchdog; it only runs while locked.
    assign timeout = enable_i && locked && !m_evt && (wd_q == WD_LAST);

    always_comb begin
        wd_d = wd_q + WD_W'(1);
        if (!enable_i || !locked || m_evt || timeout) begin
            wd_d = '0;
        end
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_i) begin
        if (!RST_IP_i) begin
            wd_q   <= '0;
            lost_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if (!enable_i) begin
                lost_q <= 1'b0;
            end else if (timeout) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign master_lost_o = lost_q;
`else
    assign master_lost_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        cnt_d   = '0;
        if (!enable_i) begin
            state_d = IDLE;
            diff_d  = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ALIGN;
                // First master word defines the local word boundary.
                ALIGN: begin
                    if (m_evt) begin
                        state_d = TRACK;
                        diff_d  = '0;
                    end
                end
                default: begin
                    cnt_d = l_evt ? '0 : cnt_q + CNT_W'(1);
                    if (m_evt && !l_evt) begin
                        diff_d = DIFF_W'(sat_step(int'(diff_q), 1'b1, DMAX));
                    end else if (l_evt && !m_evt) begin
                        diff_d = DIFF_W'(sat_step(int'(diff_q), 1'b0, DMAX));
                    end
                    case (state_q)
                        TRACK: begin
                            if (diff_q >= THR_P) begin
                                state_d = SPEEDUP;
                            end else if (diff_q <= THR_N) begin
                                state_d = SLOWDOWN;
                            end
                        end
                        SPEEDUP:  if (diff_q <= ZERO_D) state_d = TRACK;
                        SLOWDOWN: if (diff_q >= ZERO_D) state_d = TRACK;
                        default:  state_d = IDLE;
                    endcase
                end
            endcase
`ifdef FLL_TIMEOUT_EN
            if (timeout) begin
                state_d = ALIGN;
                diff_d  = '0;
                cnt_d   = '0;
            end
`endif
        end
    end

    assign locked_nxt = (state_d == TRACK) || (state_d == SPEEDUP) || (state_d == SLOWDOWN);

    always_ff @(posedge CLK_IP_i or negedge RST_IP_i) begin
        if (!RST_IP_i) begin
            state_q <= IDLE;
            diff_q  <= '0;
            cnt_q   <= '0;
            spd_q   <= 1'b0;
            slw_q   <= 1'b0;
            mah_q   <= 1'b0;
            lah_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            spd_q   <= (state_d == SPEEDUP);
            slw_q   <= (state_d == SLOWDOWN);
            // Ahead flags trail the difference register by one cycle.
            mah_q   <= locked_nxt && (diff_q > ZERO_D);
            lah_q   <= locked_nxt && (diff_q < ZERO_D);
        end
    end

    assign Interrupt_speedup         = spd_q;
    assign Interrupt_slowdown        = slw_q;
    assign master_wordcnt_is_ahead_o = mah_q;
    assign local_wordcnt_is_ahead_o  = lah_q;
    assign word_diff_o               = diff_q;
    assign locked_o                  = locked;
    assign state_o                   = state_q;

endmodule
